// File: rtl/psram_capture_writer_if.sv
// PSRAM AXI-style write port (address + data channels) between the capture writer and the memory.
interface psram_capture_writer_if;
    logic [24:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [17:0] wdata;
    logic        wvalid;
    logic        wready;
    logic        wlast;

    modport master (output awaddr, awvalid, wdata, wvalid, wlast, input awready, wready);
    modport slave  (input awaddr, awvalid, wdata, wvalid, wlast, output awready, wready);
endinterface

// File: rtl/psram_capture_writer.sv
// Packs each AD sample set into one 4-beat PSRAM burst; strobe-to-awvalid 2 cycles, FIFO absorbs stalls.
// Full FIFO drops the set and sets overflow. PSRAM_CAPTURE_WRAP_EN selects circular capture ended by stop.
module psram_capture_writer #(
    parameter int NUM_BURSTS = 800,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_psram_ready,
    input  logic        i_arm,
    input  logic        i_stop,
    input  logic        i_ad_strobe,
    input  logic [11:0] i_ad_a0,
    input  logic [11:0] i_ad_a1,
    input  logic [11:0] i_ad_b0,
    input  logic [11:0] i_ad_b1,
    input  logic [7:0]  i_ad_es,
    input  logic        i_ad_pw,
    psram_capture_writer_if.master psram,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [21:0] LAST_IDX = 22'(NUM_BURSTS - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_AW, S_W} state_t;

    state_t      r_state, w_state_nxt;
    logic [71:0] r_mem [FIFO_DEPTH];
    logic [AW:0] r_wr_ptr, r_rd_ptr;
    logic [21:0] r_burst_idx;
    logic [1:0]  r_beat;
    logic        r_done, r_overflow;
    logic        w_busy, w_empty, w_full, w_start, w_last_acc;
    logic        w_push, w_drop, w_pop, w_finish, w_stop_now, w_end_capture;
    logic [71:0] w_set, w_head;
    logic [17:0] w_beat;

    function automatic logic [17:0] fmt_beat(input logic [3:0] x, input logic [11:0] s);
        return {1'b0, x, s[11:8], 1'b0, s[7:0]};
    endfunction

    assign w_set = {fmt_beat({3'b000, i_ad_pw}, i_ad_b1), fmt_beat(4'h0, i_ad_b0),
                    fmt_beat(i_ad_es[3:0], i_ad_a1), fmt_beat(i_ad_es[7:4], i_ad_a0)};

    assign w_busy     = (r_state != S_IDLE);
    assign w_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_start    = i_arm && i_psram_ready && (r_state == S_IDLE);
    assign w_last_acc = (r_state == S_W) && (r_beat == 2'd3) && psram.wready;
    assign w_pop      = w_last_acc;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push = i_ad_strobe && w_busy && i_psram_ready && !reset && (!w_full || w_pop);
    assign w_drop = i_ad_strobe && w_busy && i_psram_ready && w_full && !w_pop;

`ifdef PSRAM_CAPTURE_WRAP_EN
    logic r_stop_req;
    assign w_stop_now    = r_stop_req || i_stop;
    assign w_end_capture = w_stop_now;
`else
    logic w_unused_stop;
    assign w_unused_stop = i_stop;
    assign w_stop_now    = 1'b0;
    assign w_end_capture = (r_burst_idx == LAST_IDX);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_finish    = 1'b0;
        case (r_state)
            S_IDLE: if (w_start) w_state_nxt = S_RUN;
            S_RUN: begin
                if (w_stop_now) begin
                    w_state_nxt = S_IDLE;
                    w_finish    = 1'b1;
                end else if (!w_empty) begin
                    w_state_nxt = S_AW;
                end
            end
            S_AW: if (psram.awready) w_state_nxt = S_W;
            S_W: begin
                if (w_last_acc) begin
                    if (w_end_capture) begin
                        w_state_nxt = S_IDLE;
                        w_finish    = 1'b1;
                    end else begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || !i_psram_ready) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_burst_idx <= '0;
            r_beat      <= '0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_burst_idx <= '0;
                r_done      <= 1'b0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
                if (w_drop) r_overflow <= 1'b1;
                if (w_last_acc)
                    r_burst_idx <= (r_burst_idx == LAST_IDX) ? 22'd0 : r_burst_idx + 22'd1;
                if (w_finish) r_done <= 1'b1;
            end
            if (r_state == S_AW && psram.awready)
                r_beat <= 2'd0;
            else if (r_state == S_W && psram.wready)
                r_beat <= r_beat + 2'd1;
        end
    end

`ifdef PSRAM_CAPTURE_WRAP_EN
    always_ff @(posedge clk) begin
        if (reset || !i_psram_ready || w_start || w_finish)
            r_stop_req <= 1'b0;
        else if (i_stop && w_busy)
            r_stop_req <= 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_set;
    end

    assign w_head = r_mem[r_rd_ptr[AW-1:0]];

    always_comb begin
        w_beat = w_head[17:0];
        case (r_beat)
            2'd1:    w_beat = w_head[35:18];
            2'd2:    w_beat = w_head[53:36];
            2'd3:    w_beat = w_head[71:54];
            default: w_beat = w_head[17:0];
        endcase
    end

    assign psram.awaddr  = {r_burst_idx, 3'b000};
    assign psram.awvalid = (r_state == S_AW);
    assign psram.wvalid  = (r_state == S_W);
    assign psram.wlast   = (r_state == S_W) && (r_beat == 2'd3);
    assign psram.wdata   = (r_state == S_W) ? w_beat : 18'd0;
    assign o_busy        = w_busy;
    assign o_done        = r_done;
    assign o_overflow    = r_overflow;
endmodule
